video_seg_argmax: RTL and testbench

Per-pixel argmax stage placed directly downstream of the temporal LPF over segmentation class scores. It consumes a beat of NUM unsigned class scores and emits the winning class index and its score. A threshold maps low-confidence pixels to a background class. An optional per-frame class histogram supports overlay and statistics logic.

---
 rtl/video_seg_argmax.sv | 215 +++++++++++++++++++++
 tb/tb_video_seg_argmax.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_seg_argmax.sv
// Per-pixel argmax over NUM unsigned class scores: registered input, pairwise compare tree, threshold stage.
// Optional per-frame class histogram is built when VIDEO_SEG_ARGMAX_HISTOGRAM_EN is defined.
module video_seg_argmax #(
    parameter int NUM        = 14,
    parameter int DATA_BITS  = 8,
    parameter int CLASS_BITS = $clog2(NUM),
    parameter int TUSER_BITS = 1,
    parameter int HIST_BITS  = 20
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [DATA_BITS-1:0]             param_threshold,
    input  logic [CLASS_BITS-1:0]            param_bg_class,
    input  logic [TUSER_BITS-1:0]            s_axi4s_tuser,
    input  logic                             s_axi4s_tlast,
    input  logic [NUM*DATA_BITS-1:0]         s_axi4s_tdata,
    input  logic                             s_axi4s_tvalid,
    output logic                             s_axi4s_tready,
    output logic [TUSER_BITS-1:0]            m_axi4s_tuser,
    output logic                             m_axi4s_tlast,
    output logic [CLASS_BITS+DATA_BITS-1:0]  m_axi4s_tdata,
    output logic                             m_axi4s_tvalid,
    input  logic                             m_axi4s_tready,
    output logic [NUM*HIST_BITS-1:0]         hist_count,
    output logic                             hist_valid
);

    localparam int LVLS   = $clog2(NUM);
    localparam int STAGES = LVLS + 2;

    // Number of surviving (score, index) entries after lv tree levels.
    function automatic int lvl_cnt(input int lv);
        int n;
        n = NUM;
        for (int k = 0; k < lv; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic cke;
    assign cke            = m_axi4s_tready || !m_axi4s_tvalid;
    assign s_axi4s_tready = cke;

    logic [STAGES-1:0]     vld_q;
    logic [STAGES-1:0]     last_q;
    logic [TUSER_BITS-1:0] user_q [STAGES];

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q <= '0;
        end else if (cke) begin
            vld_q <= {vld_q[STAGES-2:0], s_axi4s_tvalid};
        end
    end

    always_ff @(posedge aclk) begin
        if (cke) begin
            last_q    <= {last_q[STAGES-2:0], s_axi4s_tlast};
            user_q[0] <= s_axi4s_tuser;
            for (int k = 1; k < STAGES; k++) begin
                user_q[k] <= user_q[k-1];
            end
        end
    end

    // Level 0 is the input register; each later level halves the entry count.
    // Entries keep their original left-to-right order, so preferring the left
    // entry on a tie always prefers the lower class index.
    generate
        for (genvar gi = 0; gi <= LVLS; gi++) begin : g_lvl
            localparam int CNT  = lvl_cnt(gi);
            localparam int PREV = lvl_cnt(gi - 1);
            for (genvar gj = 0; gj < CNT; gj++) begin : g_ent
                logic [DATA_BITS-1:0]  sc_q;
                logic [CLASS_BITS-1:0] ix_q;
                if (gi == 0) begin : g_src
                    always_ff @(posedge aclk) begin
                        if (cke) begin
                            sc_q <= s_axi4s_tdata[gj*DATA_BITS +: DATA_BITS];
                            ix_q <= CLASS_BITS'(gj);
                        end
                    end
                end else if (2*gj + 1 < PREV) begin : g_src
                    logic [DATA_BITS-1:0]  a_score;
                    logic [DATA_BITS-1:0]  b_score;
                    logic [CLASS_BITS-1:0] a_index;
                    logic [CLASS_BITS-1:0] b_index;
                    assign a_score = g_lvl[gi-1].g_ent[2*gj].sc_q;
                    assign a_index = g_lvl[gi-1].g_ent[2*gj].ix_q;
                    assign b_score = g_lvl[gi-1].g_ent[2*gj+1].sc_q;
                    assign b_index = g_lvl[gi-1].g_ent[2*gj+1].ix_q;
                    always_ff @(posedge aclk) begin
                        if (cke) begin
                            if (b_score > a_score) begin
                                sc_q <= b_score;
                                ix_q <= b_index;
                            end else begin
                                sc_q <= a_score;
                                ix_q <= a_index;
                            end
                        end
                    end
                end else begin : g_src
                    always_ff @(posedge aclk) begin
                        if (cke) begin
                            sc_q <= g_lvl[gi-1].g_ent[2*gj].sc_q;
                            ix_q <= g_lvl[gi-1].g_ent[2*gj].ix_q;
                        end
                    end
                end
            end
        end
    endgenerate

    logic [DATA_BITS-1:0]  win_score;
    logic [CLASS_BITS-1:0] win_index;
    logic [DATA_BITS-1:0]  out_score_q;
    logic [CLASS_BITS-1:0] out_class_q;
    logic [CLASS_BITS-1:0] out_class_d;

    assign win_score = g_lvl[LVLS].g_ent[0].sc_q;
    assign win_index = g_lvl[LVLS].g_ent[0].ix_q;

    // A zero threshold can never be undercut, so it disables the background mapping.
    always_comb begin
        out_class_d = win_index;
        if (win_score < param_threshold) begin
            out_class_d = param_bg_class;
        end
    end

    always_ff @(posedge aclk) begin
        if (cke) begin
            out_score_q <= win_score;
            out_class_q <= out_class_d;
        end
    end

    assign m_axi4s_tvalid = vld_q[STAGES-1];
    assign m_axi4s_tlast  = last_q[STAGES-1];
    assign m_axi4s_tuser  = user_q[STAGES-1];
    assign m_axi4s_tdata  = {out_score_q, out_class_q};

`ifdef VIDEO_SEG_ARGMAX_HISTOGRAM_EN
    logic out_hs;
    logic out_sof;
    logic seen_q;
    logic seen_d;
    logic hist_valid_q;
    logic hist_valid_d;

    assign out_hs  = m_axi4s_tvalid && m_axi4s_tready;
    assign out_sof = out_hs && m_axi4s_tuser[0];

    always_comb begin
        seen_d       = seen_q || out_sof;
        hist_valid_d = out_sof && seen_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            seen_q       <= 1'b0;
            hist_valid_q <= 1'b0;
        end else begin
            seen_q       <= seen_d;
            hist_valid_q <= hist_valid_d;
        end
    end

    assign hist_valid = hist_valid_q;

    // A frame start closes the running frame and reopens it with the current beat.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_hist
            logic                 hit;
            logic [HIST_BITS-1:0] acc_q;
            logic [HIST_BITS-1:0] acc_d;
            logic [HIST_BITS-1:0] cnt_q;
            logic [HIST_BITS-1:0] cnt_d;

            assign hit = out_hs && (out_class_q == CLASS_BITS'(gi));

            always_comb begin
                acc_d = acc_q;
                cnt_d = cnt_q;
                if (out_sof) begin
                    acc_d = HIST_BITS'(hit);
                    if (seen_q) begin
                        cnt_d = acc_q;
                    end
                end else if (hit && (acc_q != {HIST_BITS{1'b1}})) begin
                    acc_d = acc_q + 1'b1;
                end
            end

            always_ff @(posedge aclk) begin
                if (areset) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end

            assign hist_count[gi*HIST_BITS +: HIST_BITS] = cnt_q;
        end
    endgenerate
`else
    assign hist_count = '0;
    assign hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_seg_argmax.sv
// Randomized and directed bench for video_seg_argmax against a linear-scan argmax reference model.
`timescale 1ns/1ps
module tb_video_seg_argmax;

    localparam int NUM = 14;
    localparam int DB  = 8;
    localparam int CB  = $clog2(NUM);
    localparam int UB  = 1;
    localparam int HB  = 20;
    localparam int LAT = $clog2(NUM) + 2;

    logic               aclk = 1'b0;
    logic               areset;
    logic [DB-1:0]      param_threshold;
    logic [CB-1:0]      param_bg_class;
    logic [UB-1:0]      s_axi4s_tuser;
    logic               s_axi4s_tlast;
    logic [NUM*DB-1:0]  s_axi4s_tdata;
    logic               s_axi4s_tvalid;
    logic               s_axi4s_tready;
    logic [UB-1:0]      m_axi4s_tuser;
    logic               m_axi4s_tlast;
    logic [CB+DB-1:0]   m_axi4s_tdata;
    logic               m_axi4s_tvalid;
    logic               m_axi4s_tready;
    logic [NUM*HB-1:0]  hist_count;
    logic               hist_valid;

    video_seg_argmax #(
        .NUM(NUM), .DATA_BITS(DB), .CLASS_BITS(CB), .TUSER_BITS(UB), .HIST_BITS(HB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .param_threshold(param_threshold), .param_bg_class(param_bg_class),
        .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
        .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
        .s_axi4s_tready(s_axi4s_tready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
        .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
        .m_axi4s_tready(m_axi4s_tready),
        .hist_count(hist_count), .hist_valid(hist_valid)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    typedef struct packed {
        logic          tuser;
        logic          tlast;
        logic [CB-1:0] cls;
        logic [DB-1:0] score;
    } beat_t;

    // Reference: first strictly-greater score in a left-to-right scan wins.
    function automatic beat_t model(input logic [NUM*DB-1:0] data, input logic u, input logic l,
                                    input logic [DB-1:0] thr, input logic [CB-1:0] bg);
        beat_t r;
        int best;
        int win;
        best = -1;
        win  = 0;
        for (int i = 0; i < NUM; i++) begin
            if (int'(data[i*DB +: DB]) > best) begin
                best = int'(data[i*DB +: DB]);
                win  = i;
            end
        end
        r.tuser = u;
        r.tlast = l;
        r.score = DB'(best);
        r.cls   = (best < int'(thr)) ? bg : CB'(win);
        return r;
    endfunction

    function automatic beat_t dut_beat();
        beat_t r;
        r.tuser = m_axi4s_tuser[0];
        r.tlast = m_axi4s_tlast;
        r.cls   = m_axi4s_tdata[CB-1:0];
        r.score = m_axi4s_tdata[CB +: DB];
        return r;
    endfunction

    // Scoreboard for streamed traffic
    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    int    n_in   = 0;
    int    n_out  = 0;
    bit    held_f = 1'b0;
    beat_t held;

    always @(negedge aclk) begin
        beat_t got;
        beat_t e;
        if (mon_en) begin
            got = dut_beat();
            if (held_f) begin
                check_eq("stall_valid_held", 64'(m_axi4s_tvalid), 64'(1));
                check_eq("stall_data_held", 64'(got), 64'(held));
            end
            held_f = 1'b0;
            if (m_axi4s_tvalid) begin
                if (m_axi4s_tready) begin
                    check_eq("out_has_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("stream_beat", 64'(got), 64'(e));
                        $display("[TB] beat %0d: class=%0d score=%0d tuser=%0d tlast=%0d", n_out,
                                 got.cls, got.score, got.tuser, got.tlast);
                        n_out++;
                    end
                end else begin
                    held_f = 1'b1;
                    held   = got;
                end
            end
            if (s_axi4s_tvalid && s_axi4s_tready) begin
                exp_q.push_back(model(s_axi4s_tdata, s_axi4s_tuser[0], s_axi4s_tlast,
                                      param_threshold, param_bg_class));
                n_in++;
            end
        end
    end

    int                hv_cnt = 0;
    logic [NUM*HB-1:0] hist_cap = '0;

    always @(negedge aclk) begin
        if (hist_valid) begin
            hv_cnt++;
            hist_cap = hist_count;
        end
    end

    function automatic logic [NUM*DB-1:0] fill(input int v);
        logic [NUM*DB-1:0] d;
        for (int i = 0; i < NUM; i++) d[i*DB +: DB] = DB'(v);
        return d;
    endfunction

    task automatic run_single(input string tag, input logic [NUM*DB-1:0] data,
                              input logic [DB-1:0] thr, input logic [CB-1:0] bg,
                              input int exp_cls, input int exp_score);
        int lat;
        bit done_f;
        @(posedge aclk); #1;
        param_threshold = thr;
        param_bg_class  = bg;
        s_axi4s_tdata   = data;
        s_axi4s_tuser   = 1'b1;
        s_axi4s_tlast   = 1'b1;
        s_axi4s_tvalid  = 1'b1;
        m_axi4s_tready  = 1'b1;
        @(negedge aclk);
        check_eq({tag, "_in_ready"}, 64'(s_axi4s_tready), 64'(1));
        @(posedge aclk); #1;
        s_axi4s_tvalid = 1'b0;
        lat    = 0;
        done_f = 1'b0;
        for (int k = 1; k <= 3*LAT && !done_f; k++) begin
            @(negedge aclk);
            if (m_axi4s_tvalid) begin
                lat    = k;
                done_f = 1'b1;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, "_class"}, 64'(m_axi4s_tdata[CB-1:0]), 64'(exp_cls));
        check_eq({tag, "_score"}, 64'(m_axi4s_tdata[CB +: DB]), 64'(exp_score));
        check_eq({tag, "_sideband"}, 64'({m_axi4s_tuser[0], m_axi4s_tlast}), 64'(3));
        $display("[TB] %s: class=%0d score=%0d latency=%0d", tag, m_axi4s_tdata[CB-1:0],
                 m_axi4s_tdata[CB +: DB], lat);
        @(negedge aclk);
        check_eq({tag, "_one_cycle"}, 64'(m_axi4s_tvalid), 64'(0));
    endtask

    task automatic stream_beat(input logic [NUM*DB-1:0] data, input logic u, input logic l);
        @(posedge aclk); #1;
        s_axi4s_tdata  = data;
        s_axi4s_tuser  = u;
        s_axi4s_tlast  = l;
        s_axi4s_tvalid = 1'b1;
    endtask

    function automatic logic [NUM*DB-1:0] rand_scores(input int mode);
        logic [NUM*DB-1:0] d;
        for (int i = 0; i < NUM; i++) begin
            case (mode)
                0:       d[i*DB +: DB] = DB'($urandom_range(0, 255));
                1:       d[i*DB +: DB] = DB'(50 * $urandom_range(0, 3));
                default: d[i*DB +: DB] = DB'($urandom_range(0, 40));
            endcase
        end
        return d;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM*DB-1:0] d;
        int sent;
        int cyc;
        bit acc;
        int n_seen;
        int frame_cls [16];
        int exp_cnt [NUM];
        beat_t mb;

        areset          = 1'b1;
        param_threshold = '0;
        param_bg_class  = '0;
        s_axi4s_tuser   = '0;
        s_axi4s_tlast   = 1'b0;
        s_axi4s_tdata   = '0;
        s_axi4s_tvalid  = 1'b0;
        m_axi4s_tready  = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check_eq("reset_tvalid", 64'(m_axi4s_tvalid), 64'(0));
        check_eq("reset_tready", 64'(s_axi4s_tready), 64'(1));
        check_eq("reset_hist_valid", 64'(hist_valid), 64'(0));
        check_eq("reset_hist_zero", 64'(hist_count == '0), 64'(1));

        // Directed single beats
        d = fill(10); d[5*DB +: DB] = 8'd200;
        run_single("peak5", d, 8'd0, 4'd0, 5, 200);
        d = fill(0); d[3*DB +: DB] = 8'd150; d[9*DB +: DB] = 8'd150;
        run_single("tie3_9", d, 8'd0, 4'd0, 3, 150);
        d = fill(0);
        run_single("all_zero", d, 8'd0, 4'd0, 0, 0);
        d = fill(0); d[2*DB +: DB] = 8'd80;
        run_single("below_thr", d, 8'd100, 4'd13, 13, 80);
        d = fill(0); d[2*DB +: DB] = 8'd100;
        run_single("at_thr", d, 8'd100, 4'd13, 2, 100);
        d = fill(7); d[13*DB +: DB] = 8'd255;
        run_single("last_idx", d, 8'd0, 4'd0, 13, 255);
        d = fill(0); d[12*DB +: DB] = 8'd255; d[13*DB +: DB] = 8'd255;
        run_single("tie12_13", d, 8'd0, 4'd0, 12, 255);

        // Random stream with backpressure
        param_threshold = 8'd90;
        param_bg_class  = 4'd12;
        mon_en = 1'b1;
        sent   = 0;
        cyc    = 0;
        @(posedge aclk); #1;
        s_axi4s_tvalid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            @(negedge aclk);
            acc = s_axi4s_tvalid && s_axi4s_tready;
            if (acc) sent++;
            @(posedge aclk); #1;
            cyc++;
            if (!s_axi4s_tvalid || acc) begin
                s_axi4s_tvalid = (sent < 1000) && ($urandom_range(0, 9) < 7);
                s_axi4s_tdata  = rand_scores($urandom_range(0, 2));
                s_axi4s_tuser  = UB'($urandom_range(0, 15) == 0);
                s_axi4s_tlast  = ($urandom_range(0, 7) == 0);
            end
            m_axi4s_tready = ($urandom_range(0, 9) < 6);
        end
        check_eq("stream_sent_all", 64'(sent), 64'(1000));
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            @(posedge aclk);
            cyc++;
        end
        @(negedge aclk);
        check_eq("stream_drained", 64'(exp_q.size()), 64'(0));
        check_eq("stream_in_out", 64'(n_out), 64'(n_in));
        mon_en = 1'b0;

        // Reset with three beats in flight
        @(posedge aclk); #1;
        for (int i = 0; i < 3; i++) begin
            s_axi4s_tvalid = 1'b1;
            s_axi4s_tdata  = rand_scores(0);
            s_axi4s_tuser  = UB'(i == 0);
            s_axi4s_tlast  = 1'b0;
            @(posedge aclk); #1;
        end
        s_axi4s_tvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("midreset_tvalid", 64'(m_axi4s_tvalid), 64'(0));
        n_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            if (m_axi4s_tvalid) n_seen++;
        end
        check_eq("midreset_no_beats", 64'(n_seen), 64'(0));
        check_eq("midreset_hist_zero", 64'(hist_count == '0), 64'(1));
        $display("[TB] mid-stream reset: %0d beats emerged", n_seen);

        // Histogram: one 4x4 frame, then the next frame start
        param_threshold = 8'd0;
        param_bg_class  = 4'd0;
        m_axi4s_tready  = 1'b1;
        hv_cnt = 0;
        for (int i = 0; i < 16; i++) frame_cls[i] = (i < 10) ? 1 : 4;
        for (int i = 15; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = frame_cls[i]; frame_cls[i] = frame_cls[j]; frame_cls[j] = t;
        end
        for (int c = 0; c < NUM; c++) exp_cnt[c] = 0;
        for (int i = 0; i < 16; i++) begin
            d = rand_scores(2);
            d[frame_cls[i]*DB +: DB] = DB'($urandom_range(200, 255));
            mb = model(d, i == 0, (i % 4) == 3, param_threshold, param_bg_class);
            exp_cnt[mb.cls]++;
            stream_beat(d, i == 0, (i % 4) == 3);
        end
        @(posedge aclk); #1;
        s_axi4s_tvalid = 1'b0;
        repeat (3*LAT) @(negedge aclk);
        check_eq("hist_no_first_pulse", 64'(hv_cnt), 64'(0));
        d = rand_scores(2);
        d[7*DB +: DB] = 8'd220;
        stream_beat(d, 1'b1, 1'b0);
        @(posedge aclk); #1;
        s_axi4s_tvalid = 1'b0;
        repeat (3*LAT) @(negedge aclk);
`ifdef VIDEO_SEG_ARGMAX_HISTOGRAM_EN
        check_eq("hist_one_pulse", 64'(hv_cnt), 64'(1));
        for (int c = 0; c < NUM; c++) begin
            check_eq($sformatf("hist_class%0d", c), 64'(hist_cap[c*HB +: HB]), 64'(exp_cnt[c]));
        end
        $display("[TB] histogram: class1=%0d class4=%0d pulses=%0d", hist_cap[1*HB +: HB],
                 hist_cap[4*HB +: HB], hv_cnt);
`else
        check_eq("hist_off_no_pulse", 64'(hv_cnt), 64'(0));
        check_eq("hist_off_zero", 64'(hist_count == '0), 64'(1));
        $display("[TB] histogram disabled: pulses=%0d", hv_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
